// File: rtl/pipe_regs_ctrl.sv
// IF/ID and ID/EX pipeline registers with the E/M/W valid chain, driven by the hazard
// unit's stall/flush controls, plus saturating statistics and a stuck-pipeline flag.
module pipe_regs_ctrl #(
    parameter int unsigned CTRL_W    = 12,
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned MAX_STALL = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stallF,
    input  logic              stallD,
    input  logic              flushE,
    input  logic              pcsrcD,
    input  logic [31:0]       instrF,
    input  logic [31:0]       pcplus4F,
    input  logic [4:0]        rsD,
    input  logic [4:0]        rtD,
    input  logic [4:0]        rdD,
    input  logic [CTRL_W-1:0] ctrlD,
    output logic              pcenF,
    output logic [31:0]       instrD,
    output logic [31:0]       pcplus4D,
    output logic              validD,
    output logic [4:0]        rsE,
    output logic [4:0]        rtE,
    output logic [4:0]        rdE,
    output logic [CTRL_W-1:0] ctrlE,
    output logic              validE,
    output logic              validM,
    output logic              validW,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [CNT_W-1:0]  instret,
    output logic              deadlock
);

    localparam int unsigned      RUN_W   = $clog2(MAX_STALL + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [RUN_W-1:0] runCnt;
    logic [RUN_W-1:0] runNext;
    logic             flushD;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] cnt, input logic en);
        return (en && (cnt != CNT_MAX)) ? cnt + CNT_W'(1) : cnt;
    endfunction

    // Stall wins over the branch squash, so a held instruction is never lost.
    assign pcenF  = ~stallF;
    assign flushD = pcsrcD & ~stallD;

    always_comb begin
        runNext = '0;
        if (stallD) begin
            runNext = (runCnt == RUN_MAX) ? runCnt : runCnt + RUN_W'(1);
        end
    end

    // IF/ID register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instrD   <= '0;
            pcplus4D <= '0;
            validD   <= 1'b0;
        end else if (!stallD) begin
            if (pcsrcD) begin
                instrD   <= '0;
                pcplus4D <= '0;
                validD   <= 1'b0;
            end else begin
                instrD   <= instrF;
                pcplus4D <= pcplus4F;
                validD   <= 1'b1;
            end
        end
    end

    // ID/EX register: never held, a flush inserts an all-zero bubble
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsE    <= '0;
            rtE    <= '0;
            rdE    <= '0;
            ctrlE  <= '0;
            validE <= 1'b0;
        end else if (flushE) begin
            rsE    <= '0;
            rtE    <= '0;
            rdE    <= '0;
            ctrlE  <= '0;
            validE <= 1'b0;
        end else begin
            rsE    <= rsD;
            rtE    <= rtD;
            rdE    <= rdD;
            ctrlE  <= ctrlD;
            validE <= validD;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            validM <= 1'b0;
            validW <= 1'b0;
        end else begin
            validM <= validE;
            validW <= validM;
        end
    end

    // Statistics and sticky deadlock detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            instret   <= '0;
            runCnt    <= '0;
            deadlock  <= 1'b0;
        end else begin
            stall_cnt <= satInc(stall_cnt, stallD);
            flush_cnt <= satInc(flush_cnt, flushD);
            instret   <= satInc(instret, validW);
            runCnt    <= runNext;
            if (runNext == RUN_MAX) begin
                deadlock <= 1'b1;
            end
        end
    end

endmodule
